// File: rtl/fetch_unit.sv
// fetch_unit -- LEGv8 instruction-fetch stage.
//
// Drives the external PC register and keeps at most one instruction-memory
// read in flight. Each returned word is queued with its fetch PC in a small
// FIFO that feeds decode. A redirect flushes the queue and marks any
// in-flight fetch so that its response is dropped.
//
// Parameters
//   DEPTH     instruction FIFO entries (power of two, >= 2)
//   RESET_PC  value loaded into the PC register while in reset
//
// Ports
//   i_clock / i_reset_n         clock, async active-low reset
//   i_pc                        current PC register value
//   o_pc_we / o_pc_next         PC register write enable / next value
//   o_imem_req / o_imem_addr    memory read request / address (= i_pc)
//   i_imem_gnt                  memory accepts the request this cycle
//   i_imem_rvalid / i_imem_rdata  read response
//   i_redirect / i_redirect_pc  branch or exception redirect
//   o_if_valid / i_if_ready     decode handshake on the FIFO head
//   o_if_instr / o_if_pc        head instruction and its PC
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [63:0] i_pc,
   output logic        o_pc_we,
   output logic [63:0] o_pc_next,
   output logic        o_imem_req,
   output logic [63:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [63:0] i_redirect_pc,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_instr,
   output logic [63:0] o_if_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,  // no fetch outstanding
      ST_WAIT    = 2'd1,  // fetch outstanding, response kept
      ST_DISCARD = 2'd2   // fetch outstanding, response dropped
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [63:0]     r_req_pc;
   logic [31:0]     r_instr_q [DEPTH];
   logic [63:0]     r_pc_q    [DEPTH];

   logic            w_full;
   logic            w_grant;
   logic            w_push;
   logic            w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_grant = o_imem_req & i_imem_gnt;
   // Redirect wins over both queue operations: the queue is being flushed.
   assign w_push  = (r_state == ST_WAIT) & i_imem_rvalid & ~i_redirect;
   assign w_pop   = (r_count != '0) & i_if_ready & ~i_redirect;

   assign o_imem_addr = i_pc;
   assign o_if_valid  = (r_count != '0);
   assign o_if_instr  = r_instr_q[r_rptr];
   assign o_if_pc     = r_pc_q[r_rptr];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_ISSUE;
      else            r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ISSUE: begin
            // RVALID here is a protocol error and is ignored.
            if (w_grant) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_imem_rvalid)   w_state_nxt = ST_ISSUE;
            else if (i_redirect) w_state_nxt = ST_DISCARD;
         end
         ST_DISCARD: begin
            if (i_imem_rvalid) w_state_nxt = ST_ISSUE;
         end
         default: w_state_nxt = ST_ISSUE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // PC_WE is held high through reset so the PC register keeps loading
   // RESET_PC on every edge, independent of its own reset.
   always_comb begin
      o_imem_req = 1'b0;
      o_pc_we    = 1'b0;
      o_pc_next  = i_pc + 64'd4;  // wraps modulo 2^64
      if (!i_reset_n) begin
         o_pc_we   = 1'b1;
         o_pc_next = RESET_PC;
      end else if (i_redirect) begin
         o_pc_we   = 1'b1;
         o_pc_next = {i_redirect_pc[63:2], 2'b00};
      end else if ((r_state == ST_ISSUE) && !w_full) begin
         o_imem_req = 1'b1;
         o_pc_we    = i_imem_gnt;
      end
   end

   // ---------------- queue control ----------------
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count  <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_req_pc <= RESET_PC;
      end else if (i_redirect) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_grant) r_req_pc <= i_pc;
         if (w_push)  r_wptr   <= r_wptr + AW'(1);
         if (w_pop)   r_rptr   <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; validity is carried by r_count.
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_instr_q[r_wptr] <= i_imem_rdata;
         r_pc_q[r_wptr]    <= r_req_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// The bench owns the PC register and a variable-latency instruction memory.
// The reference view is transactional: decode must see consecutive PCs
// starting at reset / at the last redirect target, each with the memory word
// for that PC, and the queue occupancy follows kept responses minus pops.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic [63:0] pc = 64'hDEAD_BEEF_0BAD_F00D;
   logic        o_pc_we;
   logic [63:0] o_pc_next;
   logic        o_imem_req;
   logic [63:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [63:0] i_redirect_pc;
   logic        o_if_valid;
   logic        i_if_ready;
   logic [31:0] o_if_instr;
   logic [63:0] o_if_pc;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clock      (clk),
      .i_reset_n    (i_reset_n),
      .i_pc         (pc),
      .o_pc_we      (o_pc_we),
      .o_pc_next    (o_pc_next),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_gnt   (i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid),
      .i_imem_rdata (i_imem_rdata),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_if_valid   (o_if_valid),
      .i_if_ready   (i_if_ready),
      .o_if_instr   (o_if_instr),
      .o_if_pc      (o_if_pc)
   );

   always #5 clk = ~clk;

   // The PC register the fetch unit wraps.
   always_ff @(posedge clk) if (o_pc_we) pc <= o_pc_next;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return 32'h8B02_0020 ^ (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
   endfunction

   // memory + reference state
   bit          pend, outst, killed;
   int          pend_cnt;
   logic [63:0] pend_addr;
   int          lat_min = 1, lat_max = 1;
   int          exp_count;
   logic [63:0] next_exp_pc;

   // per-cycle observations for directed checks
   bit          g_req, g_we, g_grant, g_pop;
   logic [63:0] g_addr, g_next, g_grant_addr, g_pop_pc;

   task automatic do_reset();
      i_reset_n = 1'b0;
      i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0;
      i_redirect = 0; i_redirect_pc = '0; i_if_ready = 0;
      pend = 0; outst = 0; killed = 0; exp_count = 0; next_exp_pc = RESET_PC;
      repeat (2) begin
         #1;
         chk("rst_pc_we", o_pc_we, 1);
         chk("rst_pc_next", o_pc_next, RESET_PC);
         chk("rst_imem_req", o_imem_req, 0);
         chk("rst_if_valid", o_if_valid, 0);
         @(negedge clk);
      end
      i_reset_n = 1'b1;
   endtask

   // One clock cycle. rmode: 0 no redirect, 1 redirect, 2 redirect only if
   // a response is presented this cycle.
   task automatic cyc(input bit gnt, input bit rdy, input int rmode, input logic [63:0] rpc);
      bit rv, redir, exp_req, grant, pop, push;
      rv = 0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin rv = 1; pend = 0; end
      end
      redir = (rmode == 1) || (rmode == 2 && rv);
      i_imem_gnt    = gnt;
      i_imem_rvalid = rv;
      i_imem_rdata  = rv ? instr_of(pend_addr) : $urandom;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_if_ready    = rdy;
      #1;
      g_req = o_imem_req; g_addr = o_imem_addr; g_we = o_pc_we; g_next = o_pc_next;
      exp_req = !outst && (exp_count < DEPTH) && !redir;
      chk("imem_req", o_imem_req, exp_req);
      chk("imem_addr", o_imem_addr, pc);
      chk("if_valid", o_if_valid, exp_count != 0);
      grant = exp_req && gnt;
      if (redir) begin
         chk("redir_pc_we", o_pc_we, 1);
         chk("redir_pc_next", o_pc_next, {rpc[63:2], 2'b00});
      end else if (grant) begin
         chk("grant_pc_we", o_pc_we, 1);
         chk("grant_pc_next", o_pc_next, pc + 64'd4);
      end else begin
         chk("idle_pc_we", o_pc_we, 0);
      end
      pop = (exp_count != 0) && rdy && !redir;
      g_pop = pop; g_pop_pc = o_if_pc;
      if (pop) begin
         chk("pop_pc", o_if_pc, next_exp_pc);
         chk("pop_instr", o_if_instr, instr_of(next_exp_pc));
         next_exp_pc += 64'd4;
      end
      push = rv && outst && !killed && !redir;
      exp_count = exp_count + int'(push) - int'(pop);
      if (rv) outst = 0;
      if (redir) begin
         exp_count = 0;
         next_exp_pc = {rpc[63:2], 2'b00};
         if (outst) killed = 1;
      end
      g_grant = grant; g_grant_addr = pc;
      if (grant) begin
         outst = 1; killed = 0; pend = 1; pend_addr = pc;
         pend_cnt = $urandom_range(lat_max, lat_min);
      end
      @(negedge clk);
   endtask

   initial begin
      bit seen;
      i_reset_n = 0;

      // ---- reset and first fetch ----
      lat_min = 1; lat_max = 1;
      do_reset();
      chk("t1_pc_after_reset", pc, 64'h0);
      cyc(1, 0, 0, '0);                       // grant at 0
      chk("t1_addr0", g_addr, 64'h0);
      chk("t1_req0", g_req, 1);
      cyc(1, 0, 0, '0);                       // response
      chk("t1_if_valid", o_if_valid, 1);
      chk("t1_if_pc", o_if_pc, 64'h0);
      chk("t1_if_instr", o_if_instr, 64'h8B02_0020);
      chk("t1_next_addr", o_imem_addr, 64'h4);

      // ---- backpressure ----
      repeat (12) cyc(1, 0, 0, '0);
      chk("bp_req_off", o_imem_req, 0);
      chk("bp_pc_hold", pc, 64'h10);
      chk("bp_count_full", o_if_valid, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0, '0);
         if (g_grant && g_grant_addr == 64'h10) seen = 1;
      end
      chk("bp_resume_0x10", seen, 1);

      // ---- redirect while a fetch is outstanding ----
      lat_min = 3; lat_max = 3;
      do_reset();
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc(1, 1, 0, '0);
         if (g_grant && g_grant_addr == 64'h8) seen = 1;
      end
      chk("rw_grant8_timeout", seen, 1);
      cyc(0, 1, 1, 64'h100);
      chk("rw_fifo_empty", o_if_valid, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1, 1, 0, '0);
         if (g_grant && !seen) begin
            chk("rw_first_addr", g_grant_addr, 64'h100);
            seen = 1;
         end
         if (g_pop) break;
      end
      chk("rw_first_pop_seen", g_pop, 1);
      chk("rw_first_if_pc", g_pop_pc, 64'h100);

      // ---- redirect coincident with response and pop ----
      lat_min = 1; lat_max = 1;
      do_reset();
      cyc(1, 0, 0, '0);                       // grant 0
      cyc(1, 0, 0, '0);                       // response 0
      cyc(1, 0, 0, '0);                       // grant 4
      cyc(1, 1, 2, 64'h100);                  // response 4 + redirect + ready
      chk("co_empty", o_if_valid, 0);
      cyc(1, 1, 0, '0);
      chk("co_req", g_req, 1);
      chk("co_addr", g_addr, 64'h100);

      // ---- wrap and alignment ----
      do_reset();
      cyc(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(1, 1, 0, '0);
      chk("wrap_grant", g_grant, 1);
      chk("wrap_pc_next", g_next, 64'h0);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 1, 64'h103);
      chk("align_pc_next", g_next, 64'h100);
      cyc(0, 1, 0, '0);
      chk("align_pc", pc, 64'h100);

      // ---- stalled grant ----
      do_reset();
      repeat (3) begin
         cyc(0, 1, 0, '0);
         chk("st_req_held", g_req, 1);
         chk("st_addr_stable", g_addr, 64'h0);
         chk("st_pc_we_low", g_we, 0);
      end
      cyc(1, 1, 0, '0);
      chk("st_grant_we", g_we, 1);
      chk("st_grant_next", g_next, 64'h4);

      // ---- randomized traffic ----
      lat_min = 1; lat_max = 3;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] t;
         int rm;
         t  = {$urandom, $urandom};
         if ($urandom_range(3, 0) == 0) t[63:8] = '1;  // exercise wrap
         rm = ($urandom_range(24, 0) == 0) ? 1 : 0;
         if (i == 1500) do_reset();
         cyc($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, rm, t);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
